// File: rtl/alu_share_arb.sv
// Arbiter time-sharing one combinational ALU between two requesters, each with a one-entry response slot.
// Optional round-robin tie-break enabled by defining ALU_ARB_RR_EN (default: fixed priority, port 0 wins ties).

module alu_share_slot #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [31:0]      alu_c,
    input  logic             alu_comp,
    input  logic [TAG_W-1:0] tag_next,
    output logic             valid,
    output logic [31:0]      c,
    output logic             comp,
    output logic [TAG_W-1:0] tag
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            c     <= '0;
            comp  <= 1'b0;
            tag   <= '0;
        end else if (load) begin
            // A load in the same cycle as a drain keeps the slot full with no bubble
            valid <= 1'b1;
            c     <= alu_c;
            comp  <= alu_comp;
            tag   <= tag_next;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end
endmodule

module alu_share_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_c,
    output logic             rsp0_comp,
    output logic [TAG_W-1:0] rsp0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_c,
    output logic             rsp1_comp,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_c,
    input  logic             alu_comp,
    output logic [1:0]       grant
);
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    alu_req_t [1:0]              req;
    logic [1:0]                  req_valid;
    logic [1:0][TAG_W-1:0]       req_tag;
    logic [1:0]                  rsp_valid;
    logic [1:0]                  rsp_ready;
    logic [1:0][31:0]            rsp_c;
    logic [1:0]                  rsp_comp;
    logic [1:0][TAG_W-1:0]       rsp_tag;
    logic [1:0]                  elig;
    logic [1:0]                  gnt;
    logic                        pick1;
    alu_req_t                    sel;

    assign req[0]    = '{op: req0_op, a: req0_a, b: req0_b};
    assign req[1]    = '{op: req1_op, a: req1_a, b: req1_b};
    assign req_valid = {req1_valid, req0_valid};
    assign req_tag   = {req1_tag, req0_tag};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // Eligible when the slot is empty or being emptied this cycle
    assign elig = req_valid & (~rsp_valid | rsp_ready);

`ifdef ALU_ARB_RR_EN
    // last_grant: 0 = port 0 served last, 1 = port 1 served last
    logic last_grant;

    assign pick1 = ~last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if (|gnt)
            last_grant <= gnt[1];
    end
`else
    assign pick1 = 1'b0;
`endif

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (&elig)
                gnt = pick1 ? 2'b10 : 2'b01;
            else
                gnt = elig;
        end
    end

    always_comb begin
        sel = '0;
        if (gnt[0])
            sel = req[0];
        else if (gnt[1])
            sel = req[1];
    end

    assign alu_op     = sel.op;
    assign alu_a      = sel.a;
    assign alu_b      = sel.b;
    assign grant      = gnt;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    for (genvar i = 0; i < 2; i++) begin : g_slot
        alu_share_slot #(.TAG_W(TAG_W)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (gnt[i]),
            .drain    (rsp_valid[i] && rsp_ready[i]),
            .alu_c    (alu_c),
            .alu_comp (alu_comp),
            .tag_next (req_tag[i]),
            .valid    (rsp_valid[i]),
            .c        (rsp_c[i]),
            .comp     (rsp_comp[i]),
            .tag      (rsp_tag[i])
        );
    end

    assign rsp0_valid = rsp_valid[0];
    assign rsp0_c     = rsp_c[0];
    assign rsp0_comp  = rsp_comp[0];
    assign rsp0_tag   = rsp_tag[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp1_c     = rsp_c[1];
    assign rsp1_comp  = rsp_comp[1];
    assign rsp1_tag   = rsp_tag[1];
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter that time-shares a single combinational ALU between two requesters, e.g. the integer pipeline and a branch/address helper unit. Each cycle it selects at most one eligible request and drives its operands and op code onto the ALU. It registers the ALU result, comparison flag and tag into that requester's one-entry response slot. Sits between the requesters and the ALU, which stays purely combinational.

## Interface

Parameters:
- `TAG_W`, default 4: width of the opaque request tag, returned unchanged with the response.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  port 0 request present
- `req0_ready`  out  1  port 0 request accepted this cycle
- `req0_op`  in  4  ALU op code (`ALU_*` encodings from defines.vh)
- `req0_a`, `req0_b`  in  32 each  operands
- `req0_tag`  in  TAG_W  request tag
- `rsp0_valid`  out  1  port 0 response slot full
- `rsp0_ready`  in  1  port 0 consumer takes response
- `rsp0_c`  out  32  registered ALU result
- `rsp0_comp`  out  1  registered ALU comparison flag
- `rsp0_tag`  out  TAG_W  tag of the request that produced it
- `req1_*`, `rsp1_*`: identical set for port 1
- `alu_a`, `alu_b`  out  32 each  to ALU
- `alu_op`  out  4  to ALU
- `alu_c`  in  32  from ALU
- `alu_comp`  in  1  from ALU
- `grant`  out  2  one-hot grant this cycle (debug/perf), 2'b00 when idle

## Operation

- **Eligibility:** port i is eligible when `reqi_valid` is high and slot i is empty, or slot i is being drained this cycle (`rspi_valid && rspi_ready`).
- **Selection:** one winner per cycle among eligible ports. `grant[i]` = `reqi_ready`, combinational. Requesters must not make `valid` depend on `ready`. Once asserted, a request holds its op, operands and tag stable until accepted.
- **ALU drive:**
  - Winner's op and operands go to `alu_op`, `alu_a`, `alu_b`.
  - With no grant, all three are driven to 0.
  - Unsupported op codes are passed through; the ALU returns 0/0.
- **Capture:** on a grant to port i, at the clock edge:
  - `rspi_c` <= `alu_c`, `rspi_comp` <= `alu_comp`, `rspi_tag` <= `reqi_tag`
  - `rspi_valid` <= 1
- **Drain:** when `rspi_valid && rspi_ready` with no new grant to i, `rspi_valid` <= 0. Data holds its last value.
- **Drain plus refill** in the same cycle: `rspi_valid` stays 1 and the slot holds new data with no bubble.
- **Ordering:** the two slots are independent. A full, stalled slot blocks only its own port.
- **Tie-break:** with both ports eligible, the tie-break rule is set by configuration. A single eligible port always wins immediately, so there is no starvation when the other port is idle.

## Timing

- Request accepted in cycle N gives response valid in cycle N+1. Throughput is 1 accepted request per cycle across both ports, and 1 per cycle per port when that slot drains every cycle.
- Reset values, applied asynchronously:
  - `rsp0_valid`, `rsp1_valid` = 0
  - `rsp*_c`, `rsp*_comp`, `rsp*_tag` = 0
  - `last_grant` pointer = 1, so port 0 wins the first tie
  - `grant`, `req*_ready`, `alu_*` = 0 while `rst` is high
- Reset mid-operation discards slot contents. Requests presented during reset are not accepted.
- `alu_c`/`alu_comp` are sampled in the same cycle the operands are driven. The ALU path (`req*` to `alu_*` to `alu_c` to slot) must close in one cycle.

## Configuration

- `ALU_ARB_RR_EN` defined: round-robin.
  - On a tie, the port not equal to `last_grant` wins.
  - `last_grant` updates on every grant, including non-contended ones.
- `ALU_ARB_RR_EN` undefined: fixed priority.
  - Port 0 always wins ties.
  - No `last_grant` register is built.
  - Port 1 can starve while port 0 stays eligible.

## Test plan

- **Single request:** port 0 presents `ALU_ADD` a=5, b=7, tag=3 -> `req0_ready`=1 same cycle; next cycle `rsp0_valid`=1, `rsp0_c`=12, `rsp0_tag`=3. Port 0 signed compare: `ALU_LT` a=32'hFFFFFFFF, b=1 -> `rsp0_comp`=1. `ALU_LTU` with the same operands -> 0.
- **Contention:** both ports valid every cycle, both `rsp_ready`=1 -> with `ALU_ARB_RR_EN`, `grant` sequence is 01,10,01,10 starting with port 0 after reset. Without it, `grant`=01 every cycle and port 1 is never served.
- **Backpressure:** `rsp0_valid`=1 with `rsp0_ready`=0 and port 0 valid -> `req0_ready`=0 and the slot holds. Port 1 `ALU_SUB` 10-3 is granted, giving `rsp1_c`=7 next cycle.
- **Drain plus refill:** slot 0 full, `rsp0_ready`=1, new port 0 request `ALU_XOR` 0xF0^0xFF -> accepted; next cycle `rsp0_valid` stays 1 with `rsp0_c`=0x0F, no idle cycle.
- **Async reset mid-stream:** assert `rst` between clock edges while both slots are full -> `rsp*_valid`=0 immediately; after release, the first tie goes to port 0.
